// File: rtl/enc_seg_pkg.sv
// ---------------------------------------------------------------------------
// enc_seg_pkg
// Shared types and constants for the encoder-to-seven-segment display path.
//   state_t       : filter/commit FSM states (IDLE, SETTLE, COMMIT)
//   SEG_*         : active-low segment patterns. Bit i = segment a..g for
//                   i = 0..6, and bit 7 = dp.
//   digit_to_seg  : maps a decimal digit 0-9 to its pattern. Any other value
//                   gives blank.
// ---------------------------------------------------------------------------
package enc_seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_D0 = 8'hC0;
    localparam logic [7:0] SEG_D1 = 8'hF9;
    localparam logic [7:0] SEG_D2 = 8'hA4;
    localparam logic [7:0] SEG_D3 = 8'hB0;
    localparam logic [7:0] SEG_D4 = 8'h99;
    localparam logic [7:0] SEG_D5 = 8'h92;
    localparam logic [7:0] SEG_D6 = 8'h82;
    localparam logic [7:0] SEG_D7 = 8'hF8;
    localparam logic [7:0] SEG_D8 = 8'h80;
    localparam logic [7:0] SEG_D9 = 8'h90;

    function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// This is a combinational decoder from one decimal digit to an active-low
// seven-segment pattern. Non-decimal codes (10-15) show blank.
//   i_digit : 4-bit digit in
//   o_seg   : 8-bit segment pattern out (bit 7 = dp, always off)
// ---------------------------------------------------------------------------
module bcd_to_seg
    import enc_seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [7:0] o_seg
);

    assign o_seg = digit_to_seg(i_digit);

endmodule

// File: rtl/enc_seg_display.sv
// ---------------------------------------------------------------------------
// enc_seg_display
// This block filters the {indicator, bcd} result of an 8-to-3 priority
// encoder. A value must stay stable for STABLE_CYCLES consecutive samples
// before the block commits it. The committed index is shown on seg0. A
// two-digit BCD count of commits to a valid value is shown on seg1 (tens)
// and seg2 (units).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         sample enable. 0 freezes sampler, counter and FSM
//   bcd[2:0]   encoder index of highest set bit
//   indicator  encoder valid
//   code_q     committed index
//   valid_q    committed indicator
//   upd        one-cycle pulse in the cycle after each commit
//   seg0       committed index digit (blank when valid_q = 0)
//   seg1/seg2  event count tens / units digit
//
// Optional feature: when the macro ENC_SEG_BLINK_EN is defined, seg0
// alternates between dash and blank while valid_q = 0. The dash phase comes
// first, and the pattern toggles every 2^BLINK_DIV cycles.
// ---------------------------------------------------------------------------
module enc_seg_display
    import enc_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned BLINK_DIV     = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] bcd,
    input  logic       indicator,
    output logic [2:0] code_q,
    output logic       valid_q,
    output logic       upd,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    // Catch illegal parameter values at elaboration.
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || BLINK_DIV < 1 || BLINK_DIV > 30) begin : g_param_check
        $error("enc_seg_display: STABLE_CYCLES must be 1..255 and BLINK_DIV 1..30");
    end

    // The mux forces bcd to zero whenever indicator is low. An undriven bcd
    // from an idle encoder therefore never reaches the sample register.
    logic [3:0] w_norm;
    assign w_norm = {indicator, (indicator ? bcd : 3'b000)};

    logic [3:0] r_in_q;
    logic [7:0] r_cnt;
    state_t     r_state;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_upd;
    logic [3:0] r_tens;
    logic [3:0] r_units;

    logic [3:0] w_committed;
    assign w_committed = {r_valid, r_code};

    // Sample register and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q <= 4'd0;
            r_cnt  <= 8'd0;
        end else if (en) begin
            r_in_q <= w_norm;
            if (w_norm != r_in_q)
                r_cnt <= 8'd0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // The commit FSM owns all output registers. The COMMIT state lasts one
    // cycle. The committed value and the upd pulse are registered on the
    // edge that leaves COMMIT, which gives the STABLE_CYCLES+2 step latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= 3'd0;
            r_valid <= 1'b0;
            r_upd   <= 1'b0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else begin
            // upd is a pulse. It drops even if en falls straight after a commit.
            r_upd <= 1'b0;
            if (en) begin
                case (r_state)
                    IDLE: begin
                        if (r_in_q != w_committed)
                            r_state <= SETTLE;
                    end
                    SETTLE: begin
                        if (r_in_q == w_committed)
                            r_state <= IDLE;
                        else if (r_cnt == CNT_MAX)
                            r_state <= COMMIT;
                    end
                    COMMIT: begin
                        // If the sample reverted on the final counting edge,
                        // there is nothing new to commit.
                        if (r_in_q != w_committed) begin
                            r_code  <= r_in_q[2:0];
                            r_valid <= r_in_q[3];
                            r_upd   <= 1'b1;
                            if (r_in_q[3]) begin
                                if (r_units == 4'd9) begin
                                    r_units <= 4'd0;
                                    r_tens  <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
                                end else begin
                                    r_units <= r_units + 4'd1;
                                end
                            end
                        end
                        r_state <= (w_norm != r_in_q) ? SETTLE : IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign code_q  = r_code;
    assign valid_q = r_valid;
    assign upd     = r_upd;

    // Three digit decoders: committed index, count tens, count units.
    logic [3:0] w_digit [3];
    logic [7:0] w_seg   [3];

    assign w_digit[0] = {1'b0, r_code};
    assign w_digit[1] = r_tens;
    assign w_digit[2] = r_units;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
        bcd_to_seg u_dec (
            .i_digit (w_digit[gi]),
            .o_seg   (w_seg[gi])
        );
    end

    logic [7:0] w_idle_seg;

`ifdef ENC_SEG_BLINK_EN
    logic [BLINK_DIV:0] r_blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_blink <= '0;
        else
            r_blink <= r_blink + 1'b1;
    end

    // Top bit low = dash phase, so dash shows first after reset.
    assign w_idle_seg = r_blink[BLINK_DIV] ? SEG_BLANK : SEG_DASH;
`else
    assign w_idle_seg = SEG_BLANK;
`endif

    assign seg0 = r_valid ? w_seg[0] : w_idle_seg;
    assign seg1 = w_seg[1];
    assign seg2 = w_seg[2];

endmodule

// File: tb/tb_enc_seg_display.sv
module tb_enc_seg_display;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] bcd;
    logic       indicator;
    logic [2:0] code_q;
    logic       valid_q;
    logic       upd;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    enc_seg_display #(.STABLE_CYCLES(4), .BLINK_DIV(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bcd       (bcd),
        .indicator (indicator),
        .code_q    (code_q),
        .valid_q   (valid_q),
        .upd       (upd),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ind;
        logic [2:0] bcd;
        int         cycles;
        logic [2:0] code;
        logic       valid;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        int         pulses;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Advance n rising edges. Outputs are sampled on the following falling
    // edge, and upd pulses are counted there.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (upd === 1'b1) pulses++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".code_q"},  {5'd0, code_q}, 8'h00);
        chk({tag, ".valid_q"}, {7'd0, valid_q}, 8'h00);
        chk({tag, ".upd"},     {7'd0, upd}, 8'h00);
        chk({tag, ".seg0"},    seg0, 8'hFF);
        chk({tag, ".seg1"},    seg1, 8'hC0);
        chk({tag, ".seg2"},    seg2, 8'hC0);
    endtask

    initial begin
        // Table of directed windows, applied after test 1 (count = 01, code 5).
        vecs[0] = '{1'b1, 1'b1, 3'd3,   2, 3'd5, 1'b1, 8'h92, 8'hC0, 8'hF9, 0}; // short glitch
        vecs[1] = '{1'b1, 1'b1, 3'd5,   6, 3'd5, 1'b1, 8'h92, 8'hC0, 8'hF9, 0}; // back to committed
        vecs[2] = '{1'b1, 1'b0, 3'bxxx, 8, 3'd0, 1'b0, 8'hFF, 8'hC0, 8'hF9, 1}; // invalid, bcd X
        vecs[3] = '{1'b1, 1'b1, 3'd7,   8, 3'd7, 1'b1, 8'hF8, 8'hC0, 8'hA4, 1};
        vecs[4] = '{1'b1, 1'b1, 3'd0,   8, 3'd0, 1'b1, 8'hC0, 8'hC0, 8'hB0, 1};
        vecs[5] = '{1'b1, 1'b0, 3'bxxx, 8, 3'd0, 1'b0, 8'hFF, 8'hC0, 8'hB0, 1};
        vecs[6] = '{1'b1, 1'b1, 3'd4,   3, 3'd0, 1'b0, 8'hFF, 8'hC0, 8'hB0, 0}; // glitch S-1 long
        vecs[7] = '{1'b1, 1'b0, 3'd0,   6, 3'd0, 1'b0, 8'hFF, 8'hC0, 8'hB0, 0};
        vecs[8] = '{1'b0, 1'b1, 3'd6,  10, 3'd0, 1'b0, 8'hFF, 8'hC0, 8'hB0, 0}; // frozen
        vecs[9] = '{1'b1, 1'b0, 3'd0,   4, 3'd0, 1'b0, 8'hFF, 8'hC0, 8'hB0, 0};

        rst_n = 1'b0; en = 1'b0; indicator = 1'b0; bcd = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Test 1: step to {1,5}. The commit shows at edge 6, with one upd pulse.
        en = 1'b1; indicator = 1'b1; bcd = 3'd5; pulses = 0;
        tick(5);
        chk("t1.code_q_edge5", {5'd0, code_q}, 8'h00);
        chk("t1.upd_edge5", {7'd0, upd}, 8'h00);
        tick(1);
        chk("t1.code_q", {5'd0, code_q}, 8'h05);
        chk("t1.valid_q", {7'd0, valid_q}, 8'h01);
        chk("t1.seg0", seg0, 8'h92);
        chk("t1.upd_edge6", {7'd0, upd}, 8'h01);
        chk("t1.seg1", seg1, 8'hC0);
        chk("t1.seg2", seg2, 8'hF9);
        tick(2);
        chk_int("t1.pulses", pulses, 1);

        // Table-driven windows.
        for (int i = 0; i < 10; i++) begin
            en = vecs[i].en; indicator = vecs[i].ind; bcd = vecs[i].bcd;
            pulses = 0;
            tick(vecs[i].cycles);
            $display("vec %0d en=%b ind=%b bcd=%b cycles=%0d", i, vecs[i].en, vecs[i].ind, vecs[i].bcd, vecs[i].cycles);
            chk($sformatf("v%0d.code_q", i), {5'd0, code_q}, {5'd0, vecs[i].code});
            chk($sformatf("v%0d.valid_q", i), {7'd0, valid_q}, {7'd0, vecs[i].valid});
            chk($sformatf("v%0d.seg0", i), seg0, vecs[i].s0);
            chk($sformatf("v%0d.seg1", i), seg1, vecs[i].s1);
            chk($sformatf("v%0d.seg2", i), seg2, vecs[i].s2);
            chk_int($sformatf("v%0d.pulses", i), pulses, vecs[i].pulses);
            chk_int($sformatf("v%0d.no_x", i),
                    int'($isunknown({code_q, valid_q, upd, seg0, seg1, seg2})), 0);
        end

        // Test 5: pause in SETTLE. Three enabled edges remain after en rises.
        en = 1'b1; indicator = 1'b1; bcd = 3'd6;
        tick(3);
        en = 1'b0;
        tick(10);
        chk("t5.code_q_paused", {5'd0, code_q}, 8'h00);
        en = 1'b1;
        tick(2);
        chk("t5.valid_q_early", {7'd0, valid_q}, 8'h00);
        chk("t5.upd_early", {7'd0, upd}, 8'h00);
        tick(1);
        chk("t5.code_q", {5'd0, code_q}, 8'h06);
        chk("t5.upd", {7'd0, upd}, 8'h01);
        chk("t5.seg0", seg0, 8'h82);
        chk("t5.seg2", seg2, 8'h99);
        tick(1);

        // Test 6a: reset asserted while in COMMIT (after edge 5 of a new step).
        bcd = 3'd2;
        tick(5);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6a");
        @(negedge clk);
        rst_n = 1'b1;

        // Test 6b: reset asserted in the upd cycle, so upd drops without an edge.
        tick(6);
        chk("t6b.upd_before", {7'd0, upd}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6b");
        @(negedge clk);
        rst_n = 1'b1;

        // Test 4: 100 alternating valid commits wrap the count 99 -> 00.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            bcd = (i % 2 == 1) ? 3'd2 : 3'd1;
            tick(8);
            if (i == 98) begin
                chk("t4.seg1_99", seg1, 8'h90);
                chk("t4.seg2_99", seg2, 8'h90);
            end
        end
        chk_int("t4.pulses", pulses, 100);
        chk("t4.seg1", seg1, 8'hC0);
        chk("t4.seg2", seg2, 8'hC0);
        chk("t4.seg0", seg0, 8'hA4);
        chk("t4.code_q", {5'd0, code_q}, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
